mips_regfile: RTL and testbench

- 32-entry general-purpose register file for the single-cycle MIPS datapath, directly upstream of the ALU.
- Supplies the ALU's a/b operands from two read ports and accepts the ALU result back on one write port.
- Applies MIPS overflow-trap write suppression using the ALU overflow flag.
- Holds a sticky overflow status register for software/debug.

---
 rtl/mips_regfile.sv | 94 +++++++++
 tb/tb_mips_regfile.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mips_regfile.sv
// 32-entry MIPS general-purpose register file with write-through read bypass,
// overflow-trap write suppression, a sticky overflow status flag and a commit counter.
module mips_regfile #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] raddr_a,
   input  logic [ADDR_W-1:0] raddr_b,
   output logic [DATA_W-1:0] rdata_a,
   output logic [DATA_W-1:0] rdata_b,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              ovf_in,
   input  logic              trap_en,
   input  logic              ovf_clr,
   output logic              ovf_trap,
   output logic              ovf_status,
   output logic [15:0]       wr_count
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic              ovf_trap_q, ovf_trap_d;
   logic              ovf_status_q, ovf_status_d;
   logic [15:0]       wr_count_q, wr_count_d;

   logic suppress;
   logic commit;

   // Gating with rst_n keeps the bypass from leaking wdata while held in reset.
   assign suppress = we && ovf_in && trap_en;
   assign commit   = rst_n && we && (waddr != '0) && !suppress;

   always_comb begin
      mem_d = mem_q;
      if (commit) begin
         mem_d[waddr] = wdata;
      end
   end

   always_comb begin
      ovf_trap_d   = suppress;
      ovf_status_d = suppress || (ovf_status_q && !ovf_clr);
      wr_count_d   = wr_count_q;
      if (commit) begin
         wr_count_d = wr_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         ovf_trap_q   <= 1'b0;
         ovf_status_q <= 1'b0;
         wr_count_q   <= '0;
      end else begin
         mem_q        <= mem_d;
         ovf_trap_q   <= ovf_trap_d;
         ovf_status_q <= ovf_status_d;
         wr_count_q   <= wr_count_d;
      end
   end

   // Address 0 is forced to zero on read; commit never targets it, so no bypass there either.
   always_comb begin
      rdata_a = mem_q[raddr_a];
      if (raddr_a == '0) begin
         rdata_a = '0;
      end else if (commit && (raddr_a == waddr)) begin
         rdata_a = wdata;
      end
   end

   always_comb begin
      rdata_b = mem_q[raddr_b];
      if (raddr_b == '0) begin
         rdata_b = '0;
      end else if (commit && (raddr_b == waddr)) begin
         rdata_b = wdata;
      end
   end

   assign ovf_trap   = ovf_trap_q;
   assign ovf_status = ovf_status_q;
   assign wr_count   = wr_count_q;

endmodule

// File: tb/tb_mips_regfile.sv
// Self-checking bench for mips_regfile: directed vector table, reset/wrap sequences,
// and randomized traffic against an array-based reference model.
module tb_mips_regfile;

   logic        clk;
   logic        rst_n;
   logic [4:0]  raddr_a, raddr_b, waddr;
   logic [31:0] rdata_a, rdata_b, wdata;
   logic        we, ovf_in, trap_en, ovf_clr;
   logic        ovf_trap, ovf_status;
   logic [15:0] wr_count;

   int errors = 0;
   int checks = 0;

   // Reference model state
   logic [31:0] m_regs [32];
   logic [15:0] m_cnt;
   logic        m_trap, m_status;

   mips_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .raddr_a(raddr_a), .raddr_b(raddr_b),
      .rdata_a(rdata_a), .rdata_b(rdata_b),
      .we(we), .waddr(waddr), .wdata(wdata),
      .ovf_in(ovf_in), .trap_en(trap_en), .ovf_clr(ovf_clr),
      .ovf_trap(ovf_trap), .ovf_status(ovf_status), .wr_count(wr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        ovf, trap, clr;
      logic [4:0]  ra, rb;
      logic [31:0] exp_a, exp_b;
      logic        exp_trap, exp_status;
      logic [15:0] exp_cnt;
   } vec_t;

   vec_t vecs [14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_cnt    = 16'h0;
      m_trap   = 1'b0;
      m_status = 1'b0;
   endtask

   function automatic logic [31:0] model_read(input logic [4:0] a);
      logic sup;
      sup = we && ovf_in && trap_en;
      if (a == 5'd0) return 32'h0;
      if (we && !sup && waddr != 5'd0 && a == waddr) return wdata;
      return m_regs[a];
   endfunction

   task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                        input logic ov, input logic tr, input logic cl,
                        input logic [4:0] ra, input logic [4:0] rb);
      we = w; waddr = wa; wdata = wd; ovf_in = ov; trap_en = tr; ovf_clr = cl;
      raddr_a = ra; raddr_b = rb;
   endtask

   // Advance one clock; the model commits what the inputs asked for at that edge.
   task automatic tick();
      logic sup;
      logic com;
      sup = we && ovf_in && trap_en;
      com = we && (waddr != 5'd0) && !sup;
      @(posedge clk);
      if (com) begin
         m_regs[waddr] = wdata;
         m_cnt = m_cnt + 16'd1;
      end
      m_status = sup || (m_status && !ovf_clr);
      m_trap   = sup;
      #1;
   endtask

   initial begin
      // Directed table, following on from a clean reset.
      vecs[0]  = '{1'b1, 5'd3, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b0, 5'd3, 5'd0, 32'h7FFFFFFF, 32'h0,        1'b0, 1'b0, 16'd1};
      vecs[1]  = '{1'b1, 5'd4, 32'hFFFFFFEC, 1'b0, 1'b0, 1'b0, 5'd3, 5'd4, 32'h7FFFFFFF, 32'hFFFFFFEC, 1'b0, 1'b0, 16'd2};
      vecs[2]  = '{1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 5'd0, 5'd4, 32'h0,        32'hFFFFFFEC, 1'b0, 1'b0, 16'd2};
      vecs[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 5'd3, 5'd4, 32'h7FFFFFFF, 32'hFFFFFFEC, 1'b0, 1'b0, 16'd2};
      vecs[4]  = '{1'b1, 5'd7, 32'd512,      1'b0, 1'b0, 1'b0, 5'd7, 5'd7, 32'd512,      32'd512,      1'b0, 1'b0, 16'd3};
      vecs[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 5'd7, 5'd7, 32'd512,      32'd512,      1'b0, 1'b0, 16'd3};
      vecs[6]  = '{1'b1, 5'd9, 32'd100,      1'b0, 1'b0, 1'b0, 5'd9, 5'd9, 32'd100,      32'd100,      1'b0, 1'b0, 16'd4};
      vecs[7]  = '{1'b1, 5'd9, 32'h80000000, 1'b1, 1'b1, 1'b0, 5'd9, 5'd9, 32'd100,      32'd100,      1'b1, 1'b1, 16'd4};
      vecs[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 5'd9, 5'd9, 32'd100,      32'd100,      1'b0, 1'b1, 16'd4};
      vecs[9]  = '{1'b1, 5'd9, 32'h80000000, 1'b1, 1'b0, 1'b0, 5'd9, 5'd3, 32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b1, 16'd5};
      vecs[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b1, 5'd9, 5'd9, 32'h80000000, 32'h80000000, 1'b0, 1'b0, 16'd5};
      vecs[11] = '{1'b1, 5'd0, 32'h1,        1'b1, 1'b1, 1'b1, 5'd0, 5'd9, 32'h0,        32'h80000000, 1'b1, 1'b1, 16'd5};
      vecs[12] = '{1'b1, 5'd9, 32'h5,        1'b1, 1'b1, 1'b0, 5'd9, 5'd9, 32'h80000000, 32'h80000000, 1'b1, 1'b1, 16'd5};
      vecs[13] = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 5'd9, 5'd9, 32'h80000000, 32'h80000000, 1'b0, 1'b1, 16'd5};

      rst_n = 1'b0;
      drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd3, 5'd4);
      model_reset();
      #1;
      chk("reset_rdata_a", rdata_a, 32'h0);
      chk("reset_rdata_b", rdata_b, 32'h0);
      chk("reset_cnt", {16'h0, wr_count}, 32'h0);
      chk("reset_status", {31'h0, ovf_status}, 32'h0);
      chk("reset_trap", {31'h0, ovf_trap}, 32'h0);
      #11 rst_n = 1'b1;
      @(posedge clk); #1;

      // Asynchronous reset mid-cycle after a write and a trap.
      drive(1'b1, 5'd5, 32'h1234, 1'b0, 1'b0, 1'b0, 5'd5, 5'd0);
      tick();
      drive(1'b1, 5'd6, 32'h1, 1'b1, 1'b1, 1'b0, 5'd5, 5'd0);
      tick();
      drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd5, 5'd5);
      #1;
      chk("pre_rst_reg5", rdata_a, 32'h1234);
      chk("pre_rst_status", {31'h0, ovf_status}, 32'h1);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("async_rst_reg5", rdata_a, 32'h0);
      chk("async_rst_cnt", {16'h0, wr_count}, 32'h0);
      chk("async_rst_status", {31'h0, ovf_status}, 32'h0);
      chk("async_rst_trap", {31'h0, ovf_trap}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 14; i++) begin
         drive(vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].ovf, vecs[i].trap, vecs[i].clr,
               vecs[i].ra, vecs[i].rb);
         #1;
         chk($sformatf("vec%0d_rdata_a", i), rdata_a, vecs[i].exp_a);
         chk($sformatf("vec%0d_rdata_b", i), rdata_b, vecs[i].exp_b);
         tick();
         chk($sformatf("vec%0d_trap", i), {31'h0, ovf_trap}, {31'h0, vecs[i].exp_trap});
         chk($sformatf("vec%0d_status", i), {31'h0, ovf_status}, {31'h0, vecs[i].exp_status});
         chk($sformatf("vec%0d_cnt", i), {16'h0, wr_count}, {16'h0, vecs[i].exp_cnt});
         $display("vec %0d: we=%0b waddr=%0d wdata=%h ovf=%0b trap_en=%0b clr=%0b -> trap=%0b status=%0b cnt=%0d",
                  i, vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].ovf, vecs[i].trap, vecs[i].clr,
                  ovf_trap, ovf_status, wr_count);
      end

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         logic [4:0] wa;
         wa = 5'($urandom_range(0, 31));
         drive(($urandom_range(0, 3) != 0), wa, $urandom,
               ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
               ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)),
               ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)));
         #1;
         chk("rand_rdata_a", rdata_a, model_read(raddr_a));
         chk("rand_rdata_b", rdata_b, model_read(raddr_b));
         tick();
         chk("rand_trap", {31'h0, ovf_trap}, {31'h0, m_trap});
         chk("rand_status", {31'h0, ovf_status}, {31'h0, m_status});
         chk("rand_cnt", {16'h0, wr_count}, {16'h0, m_cnt});
      end
      $display("random phase: 400 cycles, cnt=%0d", wr_count);

      // Counter wrap after 65536 commits from a fresh reset.
      drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd1, 5'd1);
      #2 rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 65536; i++) begin
         drive(1'b1, 5'd1, 32'(i), 1'b0, 1'b0, 1'b0, 5'd1, 5'd1);
         tick();
         if (i == 65534) chk("wrap_cnt_ffff", {16'h0, wr_count}, 32'h0000FFFF);
      end
      drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd1, 5'd1);
      #1;
      chk("wrap_cnt_zero", {16'h0, wr_count}, 32'h0);
      chk("wrap_model_cnt", {16'h0, wr_count}, {16'h0, m_cnt});
      chk("wrap_last_value", rdata_a, 32'd65535);
      $display("wrap phase: 65536 writes, cnt=%0d reg1=%0d", wr_count, rdata_a);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
